// File: rtl/core_pkg.sv
// Shared types and encodings for the decode stage and the single-cycle core decoder.
package core_pkg;

    typedef struct packed {
        logic       PCS;
        logic       RegW;
        logic       MemW;
        logic       MemtoReg;
        logic       ALUSrc;
        logic [1:0] ImmSrc;
        logic [2:0] RegSrc;
        logic [1:0] ALUControl;
        logic [1:0] FlagW;
        logic       NoWrite;
        logic       M_Start;
        logic [1:0] MCycleOp;
        logic       M_W;
        logic [3:0] Cond;
        logic [3:0] Rd;
    } dec_ctrl_t;

    localparam logic [1:0] MC_MUL = 2'b00;
    localparam logic [1:0] MC_DIV = 2'b01;
    localparam logic [1:0] MC_MLA = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } dec_state_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction decoder: instruction word -> control bundle + undefined flag.
// Multi-cycle ops take Rd from Instr[19:16]; all other classes from Instr[15:12].
module decode_comb
    import core_pkg::*;
#(
    parameter bit SUPPORT_MLA = 1'b1,
    parameter bit SUPPORT_DIV = 1'b1
) (
    input  logic [31:0] i_instr,
    output dec_ctrl_t   o_ctrl,
    output logic        o_undef
);

    logic [1:0] w_op;
    logic [3:0] w_cmd;
    logic       w_s;
    logic       w_is_mul;
    logic       w_is_mla;
    logic       w_is_div;
    logic       w_branch;
    logic       w_undef;
    dec_ctrl_t  w_ctrl;
    logic       w_unused;

    assign w_op     = i_instr[27:26];
    assign w_cmd    = i_instr[24:21];
    assign w_s      = i_instr[20];
    assign w_is_mul = (i_instr[27:21] == 7'b0000000) && (i_instr[7:4] == 4'b1001);
    assign w_is_mla = (i_instr[27:21] == 7'b0000001) && (i_instr[7:4] == 4'b1001);
    assign w_is_div = (i_instr[27:20] == 8'b01111111) && (i_instr[7:4] == 4'b1111);
    assign w_unused = ^{i_instr[11:8], i_instr[3:0]};

    always_comb begin
        w_ctrl      = '0;
        w_undef     = 1'b0;
        w_branch    = 1'b0;
        w_ctrl.Cond = i_instr[31:28];
        w_ctrl.Rd   = i_instr[15:12];
        // MC patterns overlap the DP and LDR/STR spaces, so they are matched first
        if (w_is_mul || w_is_mla || w_is_div) begin
            w_ctrl.Rd      = i_instr[19:16];
            w_ctrl.M_Start = 1'b1;
            w_ctrl.M_W     = 1'b1;
            if (w_is_mla) begin
                w_ctrl.MCycleOp = MC_MLA;
                w_ctrl.RegSrc   = 3'b110;
                w_undef         = !SUPPORT_MLA;
            end else if (w_is_div) begin
                w_ctrl.MCycleOp = MC_DIV;
                w_undef         = !SUPPORT_DIV;
            end else begin
                w_ctrl.MCycleOp = MC_MUL;
            end
        end else begin
            case (w_op)
                2'b00: begin
                    w_ctrl.RegW   = 1'b1;
                    w_ctrl.ALUSrc = i_instr[25];
                    if (!i_instr[25] && i_instr[4]) w_undef = 1'b1;
                    case (w_cmd)
                        4'b0100: begin
                            w_ctrl.ALUControl = ALU_ADD;
                            w_ctrl.FlagW      = w_s ? 2'b11 : 2'b00;
                        end
                        4'b0010: begin
                            w_ctrl.ALUControl = ALU_SUB;
                            w_ctrl.FlagW      = w_s ? 2'b11 : 2'b00;
                        end
                        4'b0000: begin
                            w_ctrl.ALUControl = ALU_AND;
                            w_ctrl.FlagW      = w_s ? 2'b10 : 2'b00;
                        end
                        4'b1100: begin
                            w_ctrl.ALUControl = ALU_ORR;
                            w_ctrl.FlagW      = w_s ? 2'b10 : 2'b00;
                        end
                        4'b1010, 4'b1011: begin
                            w_ctrl.ALUControl = w_cmd[0] ? ALU_ADD : ALU_SUB;
                            w_ctrl.FlagW      = 2'b11;
                            w_ctrl.NoWrite    = 1'b1;
                            w_ctrl.RegW       = 1'b0;
                            if (!w_s) w_undef = 1'b1;
                        end
                        default: w_undef = 1'b1;
                    endcase
                end
                2'b01: begin
                    if (i_instr[25]) w_undef = 1'b1;
                    w_ctrl.ALUSrc     = 1'b1;
                    w_ctrl.ImmSrc     = 2'b01;
                    w_ctrl.ALUControl = i_instr[23] ? ALU_ADD : ALU_SUB;
                    if (i_instr[20]) begin
                        w_ctrl.MemtoReg = 1'b1;
                        w_ctrl.RegW     = 1'b1;
                    end else begin
                        w_ctrl.MemW   = 1'b1;
                        w_ctrl.RegSrc = 3'b010;
                    end
                end
                2'b10: begin
                    if (!i_instr[25] || i_instr[24]) w_undef = 1'b1;
                    w_branch          = 1'b1;
                    w_ctrl.ALUSrc     = 1'b1;
                    w_ctrl.ImmSrc     = 2'b10;
                    w_ctrl.RegSrc     = 3'b001;
                    w_ctrl.ALUControl = ALU_ADD;
                end
                default: w_undef = 1'b1;
            endcase
        end
        w_ctrl.PCS = ((w_ctrl.Rd == 4'd15) && w_ctrl.RegW) || w_branch;
        // Undefined words still flow downstream but must not change any state
        if (w_undef) begin
            w_ctrl.RegW    = 1'b0;
            w_ctrl.MemW    = 1'b0;
            w_ctrl.M_Start = 1'b0;
            w_ctrl.M_W     = 1'b0;
            w_ctrl.FlagW   = 2'b00;
            w_ctrl.PCS     = 1'b0;
        end
    end

    assign o_ctrl  = w_ctrl;
    assign o_undef = w_undef;

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage with flush and a multi-cycle (MUL/MLA/DIV) interlock.
module decode_stage
    import core_pkg::*;
#(
    parameter bit SUPPORT_MLA = 1'b1,
    parameter bit SUPPORT_DIV = 1'b1,
    parameter int MC_TIMEOUT  = 64,
    parameter int CNT_W       = $clog2(MC_TIMEOUT + 1)
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output dec_ctrl_t   out_ctrl,
    output logic        out_undef,
    input  logic        mc_done,
    output logic        mc_busy,
    output logic        mc_err
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(MC_TIMEOUT);

    dec_ctrl_t        w_dec_ctrl;
    logic             w_dec_undef;
    logic             w_accept;
    logic             w_timeout;
    dec_state_t       w_state_nxt;
    dec_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    dec_ctrl_t        r_ctrl;
    logic             r_undef;
    logic             r_err;

    decode_comb #(
        .SUPPORT_MLA(SUPPORT_MLA),
        .SUPPORT_DIV(SUPPORT_DIV)
    ) u_decode_comb (
        .i_instr(in_instr),
        .o_ctrl (w_dec_ctrl),
        .o_undef(w_dec_undef)
    );

    // An MC op blocks the next accept even in the cycle it is handed downstream
    assign in_ready = (r_state == ST_RUN) && !(r_valid && r_ctrl.M_Start)
                      && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_undef <= 1'b0;
        end else begin
            if (flush)         r_valid <= 1'b0;
            else if (w_accept) r_valid <= 1'b1;
            else if (out_ready) r_valid <= 1'b0;
            if (w_accept) begin
                r_ctrl  <= w_dec_ctrl;
                r_undef <= w_dec_undef;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (r_valid && out_ready && r_ctrl.M_Start) w_state_nxt = ST_MC_WAIT;
            end
            ST_MC_WAIT: begin
                if (mc_done) begin
                    w_state_nxt = ST_RUN;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == ST_RUN && w_state_nxt == ST_MC_WAIT) r_cnt <= '0;
            else if (r_state == ST_MC_WAIT && r_cnt != LP_MAX)  r_cnt <= r_cnt + CNT_W'(1);
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign out_valid = r_valid;
    assign out_ctrl  = r_ctrl;
    assign out_undef = r_undef;
    assign mc_busy   = (r_state == ST_MC_WAIT);
    assign mc_err    = r_err;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one default instance plus one with MLA disabled and a short timeout.
module tb_decode_stage;
    import core_pkg::*;

    localparam logic [31:0] I_ADD  = 32'hE0812002;
    localparam logic [31:0] I_LDR  = 32'hE5913004;
    localparam logic [31:0] I_B    = 32'hEA000002;
    localparam logic [31:0] I_MUL  = 32'hE0020190;
    localparam logic [31:0] I_MLA  = 32'hE0213192;
    localparam logic [31:0] I_DIV  = 32'hE7F201F0;

    logic        CLK;
    logic        RESET;
    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic        a_out_undef, a_mc_done, a_mc_busy, a_mc_err;
    logic [31:0] a_in_instr;
    dec_ctrl_t   a_out_ctrl;
    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic        b_out_undef, b_mc_done, b_mc_busy, b_mc_err;
    logic [31:0] b_in_instr;
    dec_ctrl_t   b_out_ctrl;

    int n_chk;
    int n_err;

    logic [31:0] tv_i [6];
    dec_ctrl_t   tv_e [6];
    logic        tv_u [6];
    dec_ctrl_t   e_add, e_ldr, e_b;

    decode_stage dut_a (
        .CLK(CLK), .RESET(RESET),
        .in_valid(a_in_valid), .in_instr(a_in_instr), .in_ready(a_in_ready),
        .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ctrl(a_out_ctrl), .out_undef(a_out_undef),
        .mc_done(a_mc_done), .mc_busy(a_mc_busy), .mc_err(a_mc_err)
    );

    decode_stage #(.SUPPORT_MLA(1'b0), .MC_TIMEOUT(8)) dut_b (
        .CLK(CLK), .RESET(RESET),
        .in_valid(b_in_valid), .in_instr(b_in_instr), .in_ready(b_in_ready),
        .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ctrl(b_out_ctrl), .out_undef(b_out_undef),
        .mc_done(b_mc_done), .mc_busy(b_mc_busy), .mc_err(b_mc_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    function automatic dec_ctrl_t mk(
        input logic pcs, input logic regw, input logic memw, input logic mtr,
        input logic asrc, input logic [1:0] imms, input logic [2:0] rsrc,
        input logic [1:0] aluc, input logic [1:0] fw, input logic nw,
        input logic ms, input logic [1:0] mop, input logic mw, input logic [3:0] rd);
        dec_ctrl_t c;
        c.PCS = pcs; c.RegW = regw; c.MemW = memw; c.MemtoReg = mtr;
        c.ALUSrc = asrc; c.ImmSrc = imms; c.RegSrc = rsrc; c.ALUControl = aluc;
        c.FlagW = fw; c.NoWrite = nw; c.M_Start = ms; c.MCycleOp = mop;
        c.M_W = mw; c.Cond = 4'hE; c.Rd = rd;
        return c;
    endfunction

    initial begin
        n_chk = 0;
        n_err = 0;
        e_add = mk(0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 4'd2);
        e_ldr = mk(0, 1, 0, 1, 1, 2'd1, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 4'd3);
        e_b   = mk(1, 0, 0, 0, 1, 2'd2, 3'd1, 2'd0, 2'd0, 0, 0, 2'd0, 0, 4'd0);
        tv_i[0] = 32'hE0521003; tv_e[0] = mk(0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd1, 2'd3, 0, 0, 2'd0, 0, 4'd1);  tv_u[0] = 1'b0;
        tv_i[1] = 32'hE3510005; tv_e[1] = mk(0, 0, 0, 0, 1, 2'd0, 3'd0, 2'd1, 2'd3, 1, 0, 2'd0, 0, 4'd0);  tv_u[1] = 1'b0;
        tv_i[2] = 32'hE5013004; tv_e[2] = mk(0, 0, 1, 0, 1, 2'd1, 3'd2, 2'd1, 2'd0, 0, 0, 2'd0, 0, 4'd3);  tv_u[2] = 1'b0;
        tv_i[3] = 32'hE0100001; tv_e[3] = mk(0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd2, 2'd2, 0, 0, 2'd0, 0, 4'd0);  tv_u[3] = 1'b0;
        tv_i[4] = 32'hE08FF000; tv_e[4] = mk(1, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 4'd15); tv_u[4] = 1'b0;
        tv_i[5] = 32'hEC000000; tv_e[5] = mk(0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 4'd0);  tv_u[5] = 1'b1;

        a_in_valid = 0; a_in_instr = '0; a_flush = 0; a_out_ready = 1; a_mc_done = 0;
        b_in_valid = 0; b_in_instr = '0; b_flush = 0; b_out_ready = 1; b_mc_done = 0;
        RESET = 1'b1;
        repeat (2) cyc();
        chk("rst_valid", 32'(a_out_valid), 32'd0);
        chk("rst_ctrl",  32'(a_out_ctrl),  32'd0);
        chk("rst_undef", 32'(a_out_undef), 32'd0);
        chk("rst_busy",  32'(a_mc_busy),   32'd0);
        chk("rst_err",   32'(a_mc_err),    32'd0);
        RESET = 1'b0;
        #1;
        chk("rst_ready", 32'(a_in_ready), 32'd1);

        // ADD, LDR, B streamed back to back
        a_in_valid = 1; a_in_instr = I_ADD;
        cyc(); a_in_instr = I_LDR; #1;
        chk("add_vld",  32'(a_out_valid), 32'd1);
        chk("add_ctrl", 32'(a_out_ctrl),  32'(e_add));
        chk("add_rdy",  32'(a_in_ready),  32'd1);
        cyc(); a_in_instr = I_B; #1;
        chk("ldr_vld",  32'(a_out_valid), 32'd1);
        chk("ldr_ctrl", 32'(a_out_ctrl),  32'(e_ldr));
        cyc(); a_in_valid = 0; #1;
        chk("b_vld",  32'(a_out_valid), 32'd1);
        chk("b_ctrl", 32'(a_out_ctrl),  32'(e_b));
        cyc(); #1;
        chk("drain_vld", 32'(a_out_valid), 32'd0);

        // MUL then ADD, released by mc_done after 10 wait cycles
        a_in_valid = 1; a_in_instr = I_MUL;
        cyc(); a_in_instr = I_ADD; #1;
        chk("mul_vld",    32'(a_out_valid),         32'd1);
        chk("mul_mstart", 32'(a_out_ctrl.M_Start),  32'd1);
        chk("mul_mop",    32'(a_out_ctrl.MCycleOp), 32'(MC_MUL));
        chk("mul_mw",     32'(a_out_ctrl.M_W),      32'd1);
        chk("mul_rd",     32'(a_out_ctrl.Rd),       32'd2);
        chk("mul_rdy",    32'(a_in_ready),          32'd0);
        cyc(); #1;
        chk("mul_busy",   32'(a_mc_busy),   32'd1);
        chk("mul_vld0",   32'(a_out_valid), 32'd0);
        chk("mul_rdy_w",  32'(a_in_ready),  32'd0);
        repeat (8) cyc();
        cyc(); a_mc_done = 1; #1;
        chk("mul_busy10", 32'(a_mc_busy),  32'd1);
        chk("mul_rdy10",  32'(a_in_ready), 32'd0);
        cyc(); a_mc_done = 0; #1;
        chk("mul_done_busy", 32'(a_mc_busy),  32'd0);
        chk("mul_done_rdy",  32'(a_in_ready), 32'd1);
        cyc(); a_in_valid = 0; #1;
        chk("add2_vld",  32'(a_out_valid), 32'd1);
        chk("add2_ctrl", 32'(a_out_ctrl),  32'(e_add));
        chk("a_err0",    32'(a_mc_err),    32'd0);

        // MLA with support enabled
        cyc(); a_in_valid = 1; a_in_instr = I_MLA;
        cyc(); a_in_valid = 0; #1;
        chk("mla_mop",    32'(a_out_ctrl.MCycleOp), 32'(MC_MLA));
        chk("mla_rsrc",   32'(a_out_ctrl.RegSrc),   32'd6);
        chk("mla_mstart", 32'(a_out_ctrl.M_Start),  32'd1);
        chk("mla_undef",  32'(a_out_undef),         32'd0);
        chk("mla_rd",     32'(a_out_ctrl.Rd),       32'd1);
        cyc(); #1;
        chk("mla_busy", 32'(a_mc_busy), 32'd1);
        a_mc_done = 1;
        cyc(); a_mc_done = 0; #1;
        chk("mla_done", 32'(a_mc_busy), 32'd0);

        // DIV, then mc_done together with flush
        a_in_valid = 1; a_in_instr = I_DIV;
        cyc(); a_in_valid = 0; #1;
        chk("div_mop",    32'(a_out_ctrl.MCycleOp), 32'(MC_DIV));
        chk("div_mstart", 32'(a_out_ctrl.M_Start),  32'd1);
        chk("div_undef",  32'(a_out_undef),         32'd0);
        cyc(); #1;
        chk("div_busy", 32'(a_mc_busy), 32'd1);
        a_mc_done = 1; a_flush = 1;
        cyc(); a_mc_done = 0; a_flush = 0; #1;
        chk("div_done", 32'(a_mc_busy),  32'd0);
        chk("div_rdy",  32'(a_in_ready), 32'd1);

        // ALU/flag/memory/PC-write/undefined table at full throughput
        a_in_valid = 1; a_in_instr = tv_i[0];
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i < 5) a_in_instr = tv_i[i + 1];
            else       a_in_valid = 0;
            #1;
            chk($sformatf("tv%0d_vld", i),   32'(a_out_valid), 32'd1);
            chk($sformatf("tv%0d_ctrl", i),  32'(a_out_ctrl),  32'(tv_e[i]));
            chk($sformatf("tv%0d_undef", i), 32'(a_out_undef), 32'(tv_u[i]));
        end
        cyc(); #1;
        chk("tv_drain", 32'(a_out_valid), 32'd0);

        // Backpressure then flush
        a_out_ready = 0; a_in_valid = 1; a_in_instr = I_ADD;
        cyc(); a_in_instr = I_LDR;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_vld",  32'(a_out_valid), 32'd1);
            chk("bp_ctrl", 32'(a_out_ctrl),  32'(e_add));
            chk("bp_rdy",  32'(a_in_ready),  32'd0);
            cyc();
        end
        a_flush = 1;
        cyc(); a_flush = 0; a_in_valid = 0; a_out_ready = 1; #1;
        chk("fl_vld",  32'(a_out_valid), 32'd0);
        cyc(); #1;
        chk("fl_vld2", 32'(a_out_valid), 32'd0);

        // mc_done in RUN is ignored
        a_mc_done = 1;
        cyc(); a_mc_done = 0; #1;
        chk("done_run", 32'(a_mc_busy), 32'd0);

        // Instance b: MLA disabled
        b_in_valid = 1; b_in_instr = I_MLA; #1;
        chk("b_rdy", 32'(b_in_ready), 32'd1);
        cyc(); b_in_valid = 0; #1;
        chk("bmla_vld",    32'(b_out_valid),        32'd1);
        chk("bmla_undef",  32'(b_out_undef),        32'd1);
        chk("bmla_regw",   32'(b_out_ctrl.RegW),    32'd0);
        chk("bmla_mstart", 32'(b_out_ctrl.M_Start), 32'd0);
        cyc(); #1;
        chk("bmla_busy", 32'(b_mc_busy), 32'd0);

        // Instance b: MUL without mc_done times out after 8 wait cycles
        b_in_valid = 1; b_in_instr = I_MUL;
        cyc(); b_in_valid = 0; #1;
        chk("bmul_mstart", 32'(b_out_ctrl.M_Start), 32'd1);
        cyc(); #1;
        chk("bto_busy1", 32'(b_mc_busy), 32'd1);
        repeat (7) cyc();
        chk("bto_busy8", 32'(b_mc_busy), 32'd1);
        chk("bto_err8",  32'(b_mc_err),  32'd0);
        cyc(); #1;
        chk("bto_run", 32'(b_mc_busy), 32'd0);
        chk("bto_err", 32'(b_mc_err),  32'd1);
        repeat (3) cyc();
        chk("bto_sticky", 32'(b_mc_err),   32'd1);
        chk("bto_rdy",    32'(b_in_ready), 32'd1);

        // Asynchronous reset in the middle of MC_WAIT
        a_in_valid = 1; a_in_instr = I_MUL;
        cyc(); a_in_valid = 0;
        cyc();
        chk("ar_busy", 32'(a_mc_busy), 32'd1);
        #2 RESET = 1'b1;
        #1;
        chk("ar_busy0", 32'(a_mc_busy),   32'd0);
        chk("ar_vld0",  32'(a_out_valid), 32'd0);
        chk("ar_err0",  32'(b_mc_err),    32'd0);
        cyc(); RESET = 1'b0; #1;
        chk("ar_rdy", 32'(a_in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked successor to the single-cycle ARM instruction decoder, sitting between fetch and execute in the pipelined core. Decodes DP, LDR/STR (±imm), B, MUL, MLA and the custom DIV into a registered control bundle. Adds a valid/ready pipeline register, flush, an undefined-instruction flag, and a multi-cycle interlock: after a MUL/MLA/DIV is handed downstream, the stage accepts nothing until the MCycle unit reports completion or a timeout expires.

## Interface
- `SUPPORT_MLA`, default 1: decode MLA (Instr[27:21]=0000001, Instr[7:4]=1001); when 0, MLA is undefined.
- `SUPPORT_DIV`, default 1: decode DIV (Instr[27:20]=01111111, Instr[7:4]=1111); when 0, DIV is undefined.
- `MC_TIMEOUT`, default 64: maximum MC_WAIT cycles, ≥2.
- `CNT_W`, default $clog2(MC_TIMEOUT+1): wait-counter width.
- `CLK` in 1: clock. One clock domain.
- `RESET` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_instr` is valid.
- `in_instr` in 32: instruction word.
- `in_ready` out 1: stage accepts this cycle.
- `flush` in 1: branch redirect; kills held and incoming instruction.
- `out_valid` out 1: `out_ctrl` is valid.
- `out_ready` in 1: execute accepts this cycle.
- `out_ctrl` out `dec_ctrl_t`: PCS, RegW, MemW, MemtoReg, ALUSrc, ImmSrc[1:0], RegSrc[2:0], ALUControl[1:0], FlagW[1:0], NoWrite, M_Start, MCycleOp[1:0], M_W, Cond[3:0], Rd[3:0].
- `out_undef` out 1: held instruction is undefined. It is qualified by `out_valid`.
- `mc_done` in 1: one-cycle pulse from the MCycle unit.
- `mc_busy` out 1: state is MC_WAIT.
- `mc_err` out 1: sticky timeout flag. Cleared only by `RESET`.

## Operation
- Decode is combinational on `in_instr` and is captured into `out_ctrl` on accept, when `in_valid & in_ready`.
- DP, LDR/STR and B field encodings and the ALU decode are unchanged from the current core: ADD, SUB, AND, ORR, CMP and CMN, negative-offset subtract, and `PCS = (Rd==15 & RegW) | Branch`.
- MCycleOp encoding: 00 MUL, 01 DIV, 10 MLA. MLA sets RegSrc = 110 so Ra is read through the third port.
- MUL, MLA and DIV set M_Start=1 and M_W=1.
- Undefined instructions and disabled ops:
  - all write enables forced to 0 (RegW, MemW, M_Start, FlagW, PCS);
  - `out_undef` = 1;
  - the instruction still flows downstream.
- States:
  - RUN → MC_WAIT when `out_valid & out_ready & out_ctrl.M_Start`.
  - MC_WAIT → RUN on `mc_done`, or when the counter reaches `MC_TIMEOUT`. A timeout sets `mc_err`.
- `in_ready` = (state==RUN) & !(out_valid & out_ctrl.M_Start) & (!out_valid | out_ready).
  - An MC op is never followed in the same cycle it leaves the stage.
- While `out_valid & !out_ready`, `out_ctrl` and `out_undef` hold stable.
- `flush`:
  - `out_valid` ← 0 next cycle; any same-cycle accept is discarded.
  - State and counter are not affected, because an issued MC op cannot be aborted.
- `flush` and `mc_done` in the same cycle: both take effect.

## Timing
- Reset values:
  - `out_valid`=0, `out_ctrl`=all 0, `out_undef`=0;
  - state=RUN, counter=0;
  - `mc_busy`=0, `mc_err`=0.
  - `in_ready`=1 after reset.
- Latency: accept in cycle N → `out_valid` in N+1.
- Throughput is 1/cycle for non-MC instructions with `out_ready` held high.
- Counter:
  - cleared on entry to MC_WAIT;
  - increments each MC_WAIT cycle;
  - saturates; no wrap.
- `mc_done` seen in MC_WAIT cycle k gives RUN at k+1, and `in_ready` may rise in cycle k+1.
- `mc_done` while in RUN is ignored.
- `RESET` asserted mid MC_WAIT returns to RUN asynchronously.

## Structure
- Package `core_pkg` holds:
  - `dec_ctrl_t`;
  - MCycleOp constants `MC_MUL`, `MC_DIV`, `MC_MLA`;
  - ALUControl constants;
  - state enum `dec_state_t`.
- Sub-module `decode_comb` is pure combinational: instr → {`dec_ctrl_t`, undef}, with SUPPORT_* passed through. It is reused by the single-cycle core.
- `decode_stage` contains only the register, FSM, counter and handshake.

## Test plan
- Reset then stream `E0812002` (ADD R2,R1,R2), `E5913004` (LDR R3,[R1,#4]), `EA000002` (B), with `out_ready`=1 → three consecutive `out_valid` cycles.
  - RegW=1 / ALUControl=00; MemtoReg=1 / ALUSrc=1; PCS=1.
- `E0020190` (MUL) followed by ADD:
  - MUL is output with M_Start=1, MCycleOp=00, and `in_ready`=0 the same cycle.
  - `mc_busy`=1; pulse `mc_done` after 10 cycles → ADD is accepted the next cycle.
- With MLA `E0213192` and `SUPPORT_MLA`=0 → `out_undef`=1, RegW=0, M_Start=0, and no MC_WAIT.
- MUL issued, `mc_done` never pulsed, `MC_TIMEOUT`=8 → after 8 MC_WAIT cycles, `mc_err`=1 (sticky) and state returns to RUN.
- Backpressure and flush:
  - Hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `out_ctrl` is stable and `in_ready`=0.
  - Assert `flush` with `out_ready` still 0 → `out_valid`=0 next cycle and the instruction is never delivered.
- Assert `RESET` mid MC_WAIT, asynchronously between edges → `mc_busy` and `out_valid` drop immediately.
